post_add_out_stage: RTL

//  Output register stage fed directly by the post-adder/subtracter. It captures each {CARRYOUT,out} result.

---
 rtl/post_add_out_stage_if.sv | 18 +
 rtl/post_add_out_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/post_add_out_stage_if.sv
// Result stream between post-adder, output stage and consumer.
//   valid / ready : transfer handshake (transfer when both high)
//   data          : result word
//   carry         : carry (add) / borrow (subtract) of the word
//   sub           : operation that produced the word (1 = subtract)
// master drives valid/data/carry/sub, slave drives ready.
interface post_add_out_stage_if #(
  parameter int unsigned WIDTH = 48
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             carry;
  logic             sub;

  modport master (output valid, output data, output carry, output sub, input ready);
  modport slave  (input valid, input data, input carry, input sub, output ready);
endinterface

// File: rtl/post_add_out_stage.sv
// Output register stage behind the post-adder/subtracter.
// Captures {carry, result} words into a 2-entry skid buffer and presents the head entry
// downstream with a valid/ready handshake. Also keeps a feedback copy of the last accepted
// word for the accumulate path and a sticky carry/borrow flag.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   rstp      synchronous datapath reset, wins over cep
//   cep       clock enable; 0 freezes all state and blocks both handshakes
//   up        slave stream from post-adder (valid, ready, data=P_IN, carry=CO_IN, sub=OPSUB)
//   dn        master stream to consumer (valid, ready, data=P, carry=CARRYOUT, sub=head opsub)
//   pcout     cascade copy of P
//   carryoutf fabric copy of CARRYOUT
//   p_fb      last accepted (possibly saturated) word
//   ovf       sticky: some accepted word had carry set
//
// Build option: define P_STAGE_SAT_EN to saturate accepted words whose carry is set
// (add -> all ones, subtract -> all zeros). Without it the wrapped word is stored as is.
module post_add_out_stage #(
  parameter int unsigned WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rstp,
  input  logic                 cep,
  post_add_out_stage_if.slave  up,
  post_add_out_stage_if.master dn,
  output logic [WIDTH-1:0]     pcout,
  output logic                 carryoutf,
  output logic [WIDTH-1:0]     p_fb,
  output logic                 ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             sub;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  entry_t           head_q, tail_q;
  entry_t           in_entry;
  logic [WIDTH-1:0] stored_data;
  logic [WIDTH-1:0] fb_q;
  logic             ovf_q;
  logic             in_ready, out_valid;
  logic             push, pop;

  // Value actually written into the buffer and the feedback register.
  always_comb begin
    stored_data = up.data;
`ifdef P_STAGE_SAT_EN
    if (up.carry) begin
      stored_data = up.sub ? '0 : '1;
    end
`endif
  end

  assign in_entry = '{data: stored_data, carry: up.carry, sub: up.sub};

  assign push = up.valid & in_ready;
  assign pop  = out_valid & dn.ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. push/pop are already qualified by cep.
  always_comb begin
    state_d = state_q;
    if (rstp) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop) begin
            state_d = StTwo;
          end else if (pop && !push) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = cep && (state_q != StTwo);
    out_valid = cep && (state_q != StEmpty);
  end

  // Buffer entries, feedback word and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      fb_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (rstp) begin
      head_q <= '0;
      tail_q <= '0;
      fb_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: if (push) head_q <= in_entry;
        StOne: begin
          // With a simultaneous pop the new word goes straight to the head.
          if (push && pop) begin
            head_q <= in_entry;
          end else if (push) begin
            tail_q <= in_entry;
          end
        end
        StTwo:   if (pop) head_q <= tail_q;
        default: ;
      endcase
      if (push) begin
        fb_q  <= stored_data;
        ovf_q <= ovf_q | up.carry;
      end
    end
  end

  // Head register is left untouched when the buffer drains, so P/CARRYOUT hold.
  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.data   = head_q.data;
  assign dn.carry  = head_q.carry;
  assign dn.sub    = head_q.sub;
  assign pcout     = head_q.data;
  assign carryoutf = head_q.carry;
  assign p_fb      = fb_q;
  assign ovf       = ovf_q;

endmodule
